// File: rtl/rom_loader.sv
// rom_loader: boot-time image loader.
//   Reads KB*1024 bytes from an SPI serial flash (READ 0x03, SPI mode 0) starting at
//   flash address BASE and writes them one byte per strobe into on-chip memory.
// Parameters:
//   KB    image size in KiB (must be > 0); N = KB*1024 bytes are loaded
//   BASE  24-bit flash byte address of the first image byte
//   AUTO  1: load starts on the first cycle after reset; 0: wait for start
// Ports:
//   clock, reset  system clock / synchronous active-high reset
//   start         one-cycle load request, ignored while busy
//   busy, done    load in progress / load completed (cleared by start or reset)
//   cs, ck, mosi  flash chip select (active low), SPI clock (clock/2), serial data out
//   miso          flash serial data in
//   w, a, d       memory write strobe, byte address, write data
module rom_loader #(
    parameter int unsigned KB   = 0,
    parameter logic [23:0] BASE = 24'h0,
    parameter bit          AUTO = 1'b1,
    localparam int unsigned N   = KB * 1024,
    localparam int unsigned AW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          cs,
    output logic          ck,
    output logic          mosi,
    input  logic          miso,
    output logic          w,
    output logic [AW-1:0] a,
    output logic [7:0]    d
);

    localparam logic [31:0]   CMD  = {8'h03, BASE};
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_CMD,
        S_DATA,
        S_DONE
    } state_t;

    state_t        state, state_n;
    logic          phase, phase_n;   // 0: ck low half of a bit, 1: ck high half
    logic [4:0]    cnt, cnt_n;       // bit index within command (0..31) or byte (0..7)
    logic [31:0]   sh, sh_n;         // command shift register
    logic [7:0]    din, din_n;       // incoming byte assembly
    logic          armed, armed_n;   // pending automatic start after reset
    logic          busy_n, done_n, cs_n, ck_n, mosi_n, w_n;
    logic [AW-1:0] a_n;
    logic [7:0]    d_n;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            phase <= 1'b0;
            cnt   <= '0;
            sh    <= '0;
            din   <= '0;
            armed <= AUTO;
            busy  <= 1'b0;
            done  <= 1'b0;
            cs    <= 1'b1;
            ck    <= 1'b0;
            mosi  <= 1'b0;
            w     <= 1'b0;
            a     <= '0;
            d     <= '0;
        end else begin
            state <= state_n;
            phase <= phase_n;
            cnt   <= cnt_n;
            sh    <= sh_n;
            din   <= din_n;
            armed <= armed_n;
            busy  <= busy_n;
            done  <= done_n;
            cs    <= cs_n;
            ck    <= ck_n;
            mosi  <= mosi_n;
            w     <= w_n;
            a     <= a_n;
            d     <= d_n;
        end
    end

    always_comb begin
        state_n = state;
        phase_n = phase;
        cnt_n   = cnt;
        sh_n    = sh;
        din_n   = din;
        armed_n = armed;
        busy_n  = busy;
        done_n  = done;
        cs_n    = cs;
        ck_n    = ck;
        mosi_n  = mosi;
        w_n     = 1'b0;
        a_n     = a;
        d_n     = d;

        case (state)
            S_IDLE: begin
                cs_n   = 1'b1;
                ck_n   = 1'b0;
                mosi_n = 1'b0;
                if (start || armed) begin
                    state_n = S_SETUP;
                    armed_n = 1'b0;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    a_n     = '0;
                end
            end

            S_SETUP: begin
                cs_n    = 1'b0;
                mosi_n  = CMD[31];
                sh_n    = CMD;
                cnt_n   = '0;
                phase_n = 1'b0;
                state_n = S_CMD;
            end

            S_CMD: begin
                if (!phase) begin
                    ck_n    = 1'b1;
                    phase_n = 1'b1;
                end else begin
                    // ck falls here; mosi moves to the next bit on the same edge
                    ck_n    = 1'b0;
                    phase_n = 1'b0;
                    if (cnt == 5'd31) begin
                        state_n = S_DATA;
                        cnt_n   = '0;
                        mosi_n  = 1'b0;
                    end else begin
                        cnt_n  = cnt + 5'd1;
                        mosi_n = sh[30];
                        sh_n   = {sh[30:0], 1'b0};
                    end
                end
            end

            S_DATA: begin
                // address advances in the cycle after each strobe, so a is stable while w=1
                if (w) begin
                    a_n = a + AW'(1);
                end
                if (!phase) begin
                    ck_n    = 1'b1;
                    phase_n = 1'b1;
                end else begin
                    ck_n    = 1'b0;
                    phase_n = 1'b0;
                    din_n   = {din[6:0], miso};
                    if (cnt == 5'd7) begin
                        d_n   = {din[6:0], miso};
                        w_n   = 1'b1;
                        cnt_n = '0;
                        if (a == LAST) begin
                            state_n = S_DONE;
                        end
                    end else begin
                        cnt_n = cnt + 5'd1;
                    end
                end
            end

            S_DONE: begin
                cs_n    = 1'b1;
                ck_n    = 1'b0;
                busy_n  = 1'b0;
                done_n  = 1'b1;
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader (KB=1, BASE=24'h0A0000). Instance 0 uses AUTO=1, instance 1 AUTO=0.
// A behavioural SPI flash per instance answers READ with (addr & 8'hFF), or 8'hFF when
// mode_ff is set; each memory write is compared with the byte expected at index k.
module tb_rom_loader;

    localparam logic [23:0] BASE_A = 24'h0A0000;
    localparam int          NB     = 1024;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] start_v = '0;
    logic [1:0] busy_v, done_v, cs_v, ck_v, mosi_v, w_v;
    logic [1:0] miso_v = '0;
    logic [9:0] a0, a1;
    logic [7:0] d0, d1;

    always #5 clock = ~clock;

    rom_loader #(.KB(1), .BASE(BASE_A), .AUTO(1'b1)) u_auto (
        .clock(clock), .reset(reset), .start(start_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .cs(cs_v[0]), .ck(ck_v[0]),
        .mosi(mosi_v[0]), .miso(miso_v[0]), .w(w_v[0]), .a(a0), .d(d0)
    );

    rom_loader #(.KB(1), .BASE(BASE_A), .AUTO(1'b0)) u_man (
        .clock(clock), .reset(reset), .start(start_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .cs(cs_v[1]), .ck(ck_v[1]),
        .mosi(mosi_v[1]), .miso(miso_v[1]), .w(w_v[1]), .a(a1), .d(d1)
    );

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int nchk = 0;
    int npass = 0;
    bit mode_ff = 1'b0;

    // flash model state
    int          fcnt [2];
    int          fdbit[2];
    logic [31:0] fcmd [2];
    logic [23:0] faddr[2];
    logic [31:0] last_cmd[2];
    int          ncmd [2];
    logic        pck [2];
    logic        pcs [2];
    logic        pmosi[2];
    logic        pdone[2];

    // records
    int nw[2], data_err[2], first_w[2], cs_fall[2], done_cyc[2], ncsf[2], nckr[2];
    int spi_viol = 0;

    initial begin
        for (int i = 0; i < 2; i++) begin
            fcnt[i] = 0; fdbit[i] = 0; fcmd[i] = '0; faddr[i] = '0; last_cmd[i] = '0;
            ncmd[i] = 0; pck[i] = 1'b0; pcs[i] = 1'b1; pmosi[i] = 1'b0; pdone[i] = 1'b0;
            nw[i] = 0; data_err[i] = 0; first_w[i] = -1; cs_fall[i] = -1;
            done_cyc[i] = -1; ncsf[i] = 0; nckr[i] = 0;
        end
    end

    always @(negedge clock) begin
        logic [9:0] av;
        logic [7:0] dv, bv, expd;
        if (cyc > 2) begin
            for (int i = 0; i < 2; i++) begin
                av = (i == 0) ? a0 : a1;
                dv = (i == 0) ? d0 : d1;
                // SPI protocol sanity
                if (cs_v[i] && ck_v[i]) spi_viol++;
                if (ck_v[i] && pck[i]) spi_viol++;
                if (ck_v[i] && (mosi_v[i] !== pmosi[i])) spi_viol++;
                if (w_v[i] && (busy_v[i] !== 1'b1 || cs_v[i] !== 1'b0)) spi_viol++;
                // flash model
                if (cs_v[i]) begin
                    fcnt[i] = 0;
                    fdbit[i] = 0;
                end else begin
                    if (ck_v[i] && !pck[i]) begin
                        nckr[i]++;
                        if (fcnt[i] < 32) begin
                            fcmd[i] = {fcmd[i][30:0], mosi_v[i]};
                            fcnt[i]++;
                            if (fcnt[i] == 32) begin
                                faddr[i] = fcmd[i][23:0];
                                last_cmd[i] = fcmd[i];
                                ncmd[i]++;
                            end
                        end
                    end
                    if (!ck_v[i] && pck[i] && fcnt[i] == 32) begin
                        bv = mode_ff ? 8'hFF : faddr[i][7:0];
                        miso_v[i] = bv[7 - fdbit[i]];
                        fdbit[i]++;
                        if (fdbit[i] == 8) begin
                            fdbit[i] = 0;
                            faddr[i] = faddr[i] + 24'd1;
                        end
                    end
                end
                if (!cs_v[i] && pcs[i]) begin
                    ncsf[i]++;
                    if (cs_fall[i] < 0) cs_fall[i] = cyc;
                end
                if (done_v[i] && !pdone[i] && done_cyc[i] < 0) done_cyc[i] = cyc;
                // scoreboard: byte k lives at flash address BASE+k
                if (w_v[i]) begin
                    expd = mode_ff ? 8'hFF : 8'((BASE_A + 24'(nw[i])) & 24'hFF);
                    if (av !== 10'(nw[i]) || dv !== expd) data_err[i]++;
                    if (nw[i] == 0) first_w[i] = cyc;
                    nw[i]++;
                end
                pck[i] = ck_v[i];
                pcs[i] = cs_v[i];
                pmosi[i] = mosi_v[i];
                pdone[i] = done_v[i];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic arm(input int i);
        nw[i] = 0; data_err[i] = 0; first_w[i] = -1; cs_fall[i] = -1;
        done_cyc[i] = -1; ncsf[i] = 0; nckr[i] = 0; ncmd[i] = 0;
    endtask

    task automatic wait_done(input int i, input string tag);
        int n;
        n = 0;
        while (done_v[i] !== 1'b1 && n < 17000) begin
            step();
            n++;
        end
        check(tag, 64'(done_v[i]), 64'd1);
    endtask

    task automatic check_idle(input string tag, input int i);
        logic [9:0] av;
        logic [7:0] dv;
        av = (i == 0) ? a0 : a1;
        dv = (i == 0) ? d0 : d1;
        check(tag, {cs_v[i], ck_v[i], mosi_v[i], w_v[i], busy_v[i], done_v[i], av, dv},
              {6'b100000, 10'd0, 8'd0});
    endtask

    int s0, s1, s2, s3;

    initial begin
        // reset state
        repeat (3) step();
        check_idle("reset_auto", 0);
        check_idle("reset_man", 1);

        // load 1: auto start after reset; manual instance stays idle for 100 cycles
        arm(0); arm(1);
        reset = 1'b0;
        s0 = cyc + 1;
        while (cyc < s0 + 100) step();
        check("man_idle_csfalls", 64'(ncsf[1]), 64'd0);
        check("man_idle_ckrises", 64'(nckr[1]), 64'd0);
        check("man_idle_cs", 64'(cs_v[1]), 64'd1);

        start_v[1] = 1'b1;
        s1 = cyc + 1;
        step();
        start_v[1] = 1'b0;

        wait_done(0, "auto_done_timeout");
        check("auto_cs_fall", 64'(cs_fall[0]), 64'(s0 + 1));
        check("auto_first_w", 64'(first_w[0]), 64'(s0 + 81));
        check("auto_done_cyc", 64'(done_cyc[0]), 64'(s0 + 66 + 16 * NB));
        check("auto_wcount", 64'(nw[0]), 64'(NB));
        check("auto_data", 64'(data_err[0]), 64'd0);
        check("auto_cmd", 64'(last_cmd[0]), 64'h030A0000);
        check("auto_busy_cs", {62'd0, busy_v[0], cs_v[0]}, 64'b01);
        check("auto_last_a", 64'(a0), 64'd1023);

        wait_done(1, "man_done_timeout");
        check("man_cs_fall", 64'(cs_fall[1]), 64'(s1 + 1));
        check("man_first_w", 64'(first_w[1]), 64'(s1 + 81));
        check("man_wcount", 64'(nw[1]), 64'(NB));
        check("man_data", 64'(data_err[1]), 64'd0);

        // start after done: done falls and busy rises on the same edge
        step();
        arm(0);
        start_v[0] = 1'b1;
        s2 = cyc + 1;
        step();
        start_v[0] = 1'b0;
        check("restart_done_busy", {62'd0, done_v[0], busy_v[0]}, 64'b01);

        // reset at cycle 500 of the load
        while (cyc < s2 + 499) step();
        reset = 1'b1;
        step();
        check_idle("midload_reset", 0);
        check("midload_wcount", 64'(nw[0]), 64'd27);
        check("midload_data", 64'(data_err[0]), 64'd0);

        // reload via AUTO; start pulsed at byte 10 must be ignored
        arm(0);
        reset = 1'b0;
        s3 = cyc + 1;
        while (cyc < s3 + 81 + 16 * 10) step();
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        check("busy_start_ignored", {62'd0, busy_v[0], cs_v[0]}, 64'b10);
        wait_done(0, "reload_done_timeout");
        check("reload_first_w", 64'(first_w[0]), 64'(s3 + 81));
        check("reload_done_cyc", 64'(done_cyc[0]), 64'(s3 + 66 + 16 * NB));
        check("reload_wcount", 64'(nw[0]), 64'(NB));
        check("reload_data", 64'(data_err[0]), 64'd0);
        check("reload_ncmd", 64'(ncmd[0]), 64'd1);
        check("reload_csfalls", 64'(ncsf[0]), 64'd1);

        // miso held at 1: every byte 8'hFF
        step();
        arm(0);
        mode_ff = 1'b1;
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        check("ff_done_cleared", 64'(done_v[0]), 64'd0);
        wait_done(0, "ff_done_timeout");
        check("ff_wcount", 64'(nw[0]), 64'(NB));
        check("ff_data", 64'(data_err[0]), 64'd0);
        check("ff_last_d", 64'(d0), 64'hFF);

        check("spi_protocol", 64'(spi_viol), 64'd0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
